// File: rtl/snake_engine.sv
`default_nettype none
// =============================================================================
// Module   : snake_engine
// Brief    : Snake body store with a multi-cycle move FSM (shift, then a
//            self-collision scan) and a registered head/body pixel query.
//            Optional macro SNAKE_WRAP_EN: the head wraps at the arena edges
//            instead of dying.
// Revision : 1.0
// =============================================================================

module snake_engine #(
  parameter int MAX_LEN = 64,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int X_MIN   = 1,
  parameter int X_MAX   = 50,
  parameter int Y_MIN   = 1,
  parameter int Y_MAX   = 35
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [X_W-1:0]               start_x,
  input  logic [Y_W-1:0]               start_y,
  input  logic                         move_tick,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  output logic                         busy,
  output logic                         done,
  output logic                         dead,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  input  logic [X_W-1:0]               px_x,
  input  logic [Y_W-1:0]               px_y,
  output logic                         px_head,
  output logic                         px_body
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [LW-1:0]  c_len_one = LW'(1);
  localparam logic [LW-1:0]  c_len_max = LW'(MAX_LEN);
  localparam logic [X_W:0]   c_x_min   = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]   c_x_max   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   c_y_min   = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0]   c_y_max   = (Y_W+1)'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_SHIFT  = 3'd2,
    S_CHECK  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [X_W-1:0] r_seg_x [MAX_LEN];
  logic [Y_W-1:0] r_seg_y [MAX_LEN];
  logic [LW-1:0]  r_len;
  logic [IW-1:0]  r_idx;
  logic [1:0]     r_dir;
  logic           r_dead;
  logic           r_grow_pend;
  logic [X_W-1:0] r_nxt_x;
  logic [Y_W-1:0] r_nxt_y;

  logic [1:0]     w_dir_eff;
  logic [X_W:0]   w_step_x;
  logic [Y_W:0]   w_step_y;
  logic [X_W-1:0] w_nxt_x;
  logic [Y_W-1:0] w_nxt_y;
  logic           w_wall;
  logic [LW-1:0]  w_len_grown;
  logic           w_hit;
  logic           w_last;
  logic           w_body_hit;

  // A request for the exact opposite direction keeps the current heading.
  always_comb begin
    w_dir_eff = (dir == (r_dir ^ 2'd2)) ? r_dir : dir;
    w_step_x  = {1'b0, r_seg_x[0]};
    w_step_y  = {1'b0, r_seg_y[0]};
    case (w_dir_eff)
      2'd0:    w_step_y = w_step_y - (Y_W+1)'(1);
      2'd1:    w_step_x = w_step_x - (X_W+1)'(1);
      2'd2:    w_step_y = w_step_y + (Y_W+1)'(1);
      default: w_step_x = w_step_x + (X_W+1)'(1);
    endcase
  end

  // The guard bit turns an underflow below zero into a value above the max.
`ifdef SNAKE_WRAP_EN
  assign w_wall  = 1'b0;
  assign w_nxt_x = (w_step_x < c_x_min) ? X_W'(X_MAX) :
                   (w_step_x > c_x_max) ? X_W'(X_MIN) : w_step_x[X_W-1:0];
  assign w_nxt_y = (w_step_y < c_y_min) ? Y_W'(Y_MAX) :
                   (w_step_y > c_y_max) ? Y_W'(Y_MIN) : w_step_y[Y_W-1:0];
`else
  assign w_wall  = (w_step_x < c_x_min) || (w_step_x > c_x_max) ||
                   (w_step_y < c_y_min) || (w_step_y > c_y_max);
  assign w_nxt_x = w_step_x[X_W-1:0];
  assign w_nxt_y = w_step_y[Y_W-1:0];
`endif

  assign w_len_grown = (r_grow_pend && (r_len < c_len_max)) ? r_len + c_len_one : r_len;
  assign w_hit       = (r_seg_x[r_idx] == r_seg_x[0]) && (r_seg_y[r_idx] == r_seg_y[0]);
  assign w_last      = (LW'(r_idx) == (r_len - c_len_one));

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FIN);
    case (r_state)
      S_IDLE:   if (move_tick && !r_dead) w_state_nxt = S_ACCEPT;
      S_ACCEPT: w_state_nxt = w_wall ? S_FIN : S_SHIFT;
      S_SHIFT:  if (r_idx == '0) w_state_nxt = (r_len == c_len_one) ? S_FIN : S_CHECK;
      S_CHECK:  if (w_hit || w_last) w_state_nxt = S_FIN;
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (start) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= X_W'(X_MIN);
        r_seg_y[i] <= Y_W'(Y_MIN);
      end
      r_len       <= c_len_one;
      r_idx       <= '0;
      r_dir       <= 2'd3;
      r_dead      <= 1'b0;
      r_grow_pend <= 1'b0;
      r_nxt_x     <= '0;
      r_nxt_y     <= '0;
    end else if (start) begin
      r_seg_x[0]  <= start_x;
      r_seg_y[0]  <= start_y;
      r_len       <= c_len_one;
      r_idx       <= '0;
      r_dir       <= 2'd3;
      r_dead      <= 1'b0;
      r_grow_pend <= 1'b0;
    end else begin
      if (grow) r_grow_pend <= 1'b1;
      case (r_state)
        S_ACCEPT: begin
          r_dir <= w_dir_eff;
          if (w_wall) begin
            r_dead <= 1'b1;
          end else begin
            r_len   <= w_len_grown;
            r_idx   <= IW'(w_len_grown - c_len_one);
            r_nxt_x <= w_nxt_x;
            r_nxt_y <= w_nxt_y;
            // A grow arriving in this very cycle belongs to the next move.
            if (!grow) r_grow_pend <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_idx == '0) begin
            r_seg_x[0] <= r_nxt_x;
            r_seg_y[0] <= r_nxt_y;
            r_idx      <= IW'(1);
          end else begin
            r_seg_x[r_idx] <= r_seg_x[r_idx - IW'(1)];
            r_seg_y[r_idx] <= r_seg_y[r_idx - IW'(1)];
            r_idx          <= r_idx - IW'(1);
          end
        end
        S_CHECK: begin
          if (w_hit) r_dead <= 1'b1;
          else       r_idx  <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Stale entries beyond the live length must never report a hit.
  always_comb begin
    w_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg_x[i] == px_x) && (r_seg_y[i] == px_y))
        w_body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_head <= 1'b0;
      px_body <= 1'b0;
    end else begin
      px_head <= (r_seg_x[0] == px_x) && (r_seg_y[0] == px_y);
      px_body <= w_body_hit;
    end
  end

  assign dead   = r_dead;
  assign length = r_len;
  assign head_x = r_seg_x[0];
  assign head_y = r_seg_y[0];

endmodule

`default_nettype wire

// File: tb/tb_snake_engine.sv
`default_nettype none
// =============================================================================
// Module   : tb_snake_engine
// Brief    : Randomised bench for snake_engine against a queue-based model of
//            the snake, plus directed scenarios with literal expectations.
// Revision : 1.0
// =============================================================================

module tb_snake_engine;

  localparam int MAX_LEN = 64;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int X_MIN   = 1;
  localparam int X_MAX   = 50;
  localparam int Y_MIN   = 1;
  localparam int Y_MAX   = 35;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [X_W-1:0] start_x;
  logic [Y_W-1:0] start_y;
  logic           move_tick;
  logic [1:0]     dir;
  logic           grow;
  logic           busy;
  logic           done;
  logic           dead;
  logic [LW-1:0]  length;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [X_W-1:0] px_x;
  logic [Y_W-1:0] px_y;
  logic           px_head;
  logic           px_body;

  always #5 clk = ~clk;

  snake_engine #(
    .MAX_LEN(MAX_LEN), .X_W(X_W), .Y_W(Y_W),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_x(start_x), .start_y(start_y),
    .move_tick(move_tick), .dir(dir), .grow(grow), .busy(busy), .done(done),
    .dead(dead), .length(length), .head_x(head_x), .head_y(head_y),
    .px_x(px_x), .px_y(px_y), .px_head(px_head), .px_body(px_body)
  );

  int total = 0;
  int bad   = 0;

  // Model: segment lists (head first), heading, flags.
  int qx[$];
  int qy[$];
  int m_dir  = 3;
  bit m_dead = 1'b0;
  bit m_pend = 1'b0;

  // Requests from the driver to the compare process (sequence-tagged).
  int req_seq = 0;
  int req_d   = 0;
  int px_seq  = 0;
  bit px_eh   = 1'b0;
  bit px_eb   = 1'b0;
  bit idle_now = 1'b0;
  bit chk_en   = 1'b0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Compare process: one negedge per cycle, DUT outputs against the model.
  int seen_seq = 0;
  int px_seen  = 0;
  int cnt      = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (req_seq != seen_seq) begin
        cnt      = req_d;
        seen_seq = req_seq;
      end
      if (cnt > 0) begin
        check("busy_in_move", int'(busy), 1);
        check("done_pulse", int'(done), int'(cnt == 1));
        cnt--;
        idle_now = 1'b0;
      end else begin
        check("busy_idle", int'(busy), 0);
        check("done_idle", int'(done), 0);
        check("head_x", int'(head_x), qx[0]);
        check("head_y", int'(head_y), qy[0]);
        check("length", int'(length), qx.size());
        check("dead", int'(dead), int'(m_dead));
        idle_now = 1'b1;
      end
      if (px_seq != px_seen) begin
        px_seen = px_seq;
        check("px_head", int'(px_head), int'(px_eh));
        check("px_body", int'(px_body), int'(px_eb));
      end
    end
  end

  task automatic model_move(input int d);
    int e, nx, ny, l, k;
    e = (d == (m_dir ^ 2)) ? m_dir : d;
    m_dir = e;
    nx = qx[0];
    ny = qy[0];
    case (e)
      0: ny = ny - 1;
      1: nx = nx - 1;
      2: ny = ny + 1;
      default: nx = nx + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx < X_MIN) nx = X_MAX; else if (nx > X_MAX) nx = X_MIN;
    if (ny < Y_MIN) ny = Y_MAX; else if (ny > Y_MAX) ny = Y_MIN;
`else
    if (nx < X_MIN || nx > X_MAX || ny < Y_MIN || ny > Y_MAX) begin
      m_dead = 1'b1;
      req_d  = 2;
      req_seq++;
      return;
    end
`endif
    if (m_pend && qx.size() < MAX_LEN) begin
      qx.push_front(nx);
      qy.push_front(ny);
    end else begin
      void'(qx.pop_back());
      void'(qy.pop_back());
      qx.push_front(nx);
      qy.push_front(ny);
    end
    m_pend = 1'b0;
    l = qx.size();
    k = l - 1;
    for (int i = 1; i < l; i++) begin
      if (qx[i] == nx && qy[i] == ny) begin
        k = i;
        m_dead = 1'b1;
        break;
      end
    end
    req_d = 1 + l + k + 1;
    req_seq++;
  endtask

  // One cycle of stimulus, applied just after the compare edge.
  task automatic step(input bit st, input int sx, input int sy, input bit tk,
                      input int d, input bit gr, input int qxx, input int qyy);
    @(negedge clk);
    #1;
    start     = st;
    start_x   = X_W'(sx);
    start_y   = Y_W'(sy);
    move_tick = tk;
    grow      = gr;
    px_x      = X_W'(qxx);
    px_y      = Y_W'(qyy);
    if (tk && idle_now) dir = 2'(d);
    if (idle_now) begin
      px_eh = (qx[0] == qxx) && (qy[0] == qyy);
      px_eb = 1'b0;
      for (int i = 1; i < qx.size(); i++)
        if (qx[i] == qxx && qy[i] == qyy) px_eb = 1'b1;
      px_seq++;
    end
    if (gr) m_pend = 1'b1;
    if (st) begin
      qx = {sx};
      qy = {sy};
      m_dir  = 3;
      m_dead = 1'b0;
      m_pend = 1'b0;
      req_d  = 0;
      req_seq++;
    end else if (tk && idle_now && !m_dead) begin
      model_move(d);
    end
  endtask

  task automatic run_until_idle(output int nb);
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      if (busy) nb++;
      if (idle_now) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic move(input int d, input bit gr, output int nb);
    step(0, 0, 0, 1, d, gr, 0, 0);
    run_until_idle(nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    reset = 1'b1; start = 1'b0; start_x = '0; start_y = '0; move_tick = 1'b0;
    dir = 2'd3; grow = 1'b0; px_x = '0; px_y = '0;
    qx = {X_MIN};
    qy = {Y_MIN};
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dead", int'(dead), 0);
    check("rst_len", int'(length), 1);
    check("rst_head_x", int'(head_x), 1);
    check("rst_head_y", int'(head_y), 1);
    check("rst_px", int'({px_head, px_body}), 0);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Single step right from (10,10).
    step(1, 10, 10, 0, 0, 0, 0, 0);
    move(3, 0, nb);
    check("t1_busy_cycles", nb, 3);
    check("t1_head_x", int'(head_x), 11);
    check("t1_head_y", int'(head_y), 10);
    check("t1_len", int'(length), 1);

    // Growing move up.
    move(0, 1, nb);
    check("t2_busy_cycles", nb, 5);
    check("t2_len", int'(length), 2);
    check("t2_head_y", int'(head_y), 9);
    step(0, 0, 0, 0, 0, 0, 11, 10);
    step(0, 0, 0, 0, 0, 0, 11, 9);
    check("t2_px_body_seg1", int'(px_body), 1);
    check("t2_px_head_seg1", int'(px_head), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_px_head_head", int'(px_head), 1);

    // Reversal while heading right is ignored.
    move(3, 0, nb);
    move(1, 0, nb);
    check("t3_head_x", int'(head_x), 13);
    check("t3_head_y", int'(head_y), 9);

    // Right-hand wall.
    step(1, X_MAX, 5, 0, 0, 0, 0, 0);
    move(3, 0, nb);
`ifdef SNAKE_WRAP_EN
    check("t4_head_x_wrap", int'(head_x), X_MIN);
    check("t4_dead_wrap", int'(dead), 0);
`else
    check("t4_busy_cycles", nb, 2);
    check("t4_dead", int'(dead), 1);
    check("t4_head_x", int'(head_x), X_MAX);
    move(0, 0, nb);
    check("t4_ignored_tick", nb, 0);
`endif

    // Tight turn into the former tail: fatal only when growing.
    for (int g = 1; g >= 0; g--) begin
      step(1, 20, 20, 0, 0, 0, 0, 0);
      repeat (3) move(3, 1, nb);
      move(0, 0, nb);
      move(1, 0, nb);
      move(2, bit'(g), nb);
      check(g ? "t5_dead_grow" : "t5_dead_nogrow", int'(dead), g);
      check(g ? "t5_len_grow" : "t5_len_nogrow", int'(length), g ? 5 : 4);
    end

    // Start in the middle of a shift, and start while dead.
    step(1, 20, 20, 0, 0, 0, 0, 0);
    repeat (2) move(3, 1, nb);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 30, 30, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_len", int'(length), 1);
    check("t6_head_x", int'(head_x), 30);
    step(1, 10, 10, 0, 0, 0, 0, 0);
    move(0, 0, nb);
    step(1, 25, 25, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_dead_cleared", int'(dead), 0);

    // Randomised play.
    for (int n = 0; n < 5000; n++) begin
      bit st, tk, gr;
      int d, j, pxx, pyy;
      st = ($urandom_range(0, 399) == 0) || (m_dead && $urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 2) == 0);
      gr = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 9) < 6) ? m_dir : int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        j   = int'($urandom_range(0, qx.size() - 1));
        pxx = qx[j];
        pyy = qy[j];
      end else begin
        pxx = int'($urandom_range(0, X_MAX + 2));
        pyy = int'($urandom_range(0, Y_MAX + 2));
      end
      step(st, int'($urandom_range(X_MIN, X_MAX)), int'($urandom_range(Y_MIN, Y_MAX)),
           tk, d, gr, pxx, pyy);
    end
    run_until_idle(nb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Parametrised snake body engine that replaces the hard-coded snake arrays and collision logic in the game datapath. It holds up to MAX_LEN segments in cell coordinates and advances the snake one cell per move_tick. A multi-cycle FSM performs the body shift and then the self-collision scan, and a registered pixel-query port lets the renderer ask whether a cell is head or body. Apple placement, border drawing and colour mixing stay outside this block.

Parameters:
MAX_LEN, 64, maximum segment count; length saturates here.
X_W, 8, x coordinate width.
Y_W, 7, y coordinate width.
X_MIN, 1, lowest legal head x (cell units).
X_MAX, 50, highest legal head x.
Y_MIN, 1, lowest legal head y.
Y_MAX, 35, highest legal head y.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; reinitialise the snake.
start_x  in  X_W  initial head x, sampled on start.
start_y  in  Y_W  initial head y, sampled on start.
move_tick  in  1  one-cycle pulse; request a one-cell move.
dir  in  2  requested direction: 0 = up (y-1), 1 = left (x-1), 2 = down (y+1), 3 = right (x+1).
grow  in  1  pulse; the next move lengthens the snake by 1.
busy  out  1  high while the FSM is not IDLE.
done  out  1  one-cycle pulse when a move completes.
dead  out  1  sticky collision flag.
length  out  $clog2(MAX_LEN+1)  current segment count.
head_x  out  X_W  segment 0 x.
head_y  out  Y_W  segment 0 y.
px_x  in  X_W  query cell x.
px_y  in  Y_W  query cell y.
px_head  out  1  query hit on head; 1-cycle latency.
px_body  out  1  query hit on any segment 1..length-1; 1-cycle latency.

Behaviour:
- Reset values:
  - length = 1, head = (X_MIN, Y_MIN), cur_dir = right.
  - busy, done, dead, px_head, px_body = 0; grow_pending = 0; state = IDLE.
- States: IDLE, ACCEPT, SHIFT, CHECK, FIN.
- start:
  - Takes effect from any state and has priority over move_tick and grow.
  - Next cycle: length = 1, seg[0] = (start_x, start_y), cur_dir = right, dead = 0, grow_pending = 0, state = IDLE, no done pulse.
- grow:
  - Sets grow_pending in any state.
  - grow_pending is cleared when consumed at ACCEPT.
- move_tick:
  - Accepted only in IDLE with dead = 0; ignored otherwise (not queued).
- IDLE to ACCEPT on an accepted tick. In ACCEPT:
  - cur_dir = dir, unless dir is the opposite of cur_dir (reversal is ignored).
  - Compute nxt head with one guard bit per axis.
  - If nxt is outside [X_MIN..X_MAX] x [Y_MIN..Y_MAX]: dead = 1, no state change to the segments, go to FIN.
  - Otherwise: if grow_pending and length < MAX_LEN, length += 1. Then idx = length - 1 and go to SHIFT.
- SHIFT:
  - Each cycle: seg[idx] = seg[idx-1], idx -= 1.
  - When idx reaches 0: seg[0] = nxt, idx = 1, go to CHECK.
  - With length 1, exactly one SHIFT cycle runs, which writes only the head.
- CHECK:
  - Each cycle compare seg[idx] with seg[0] while idx < length.
  - On a match: dead = 1, go to FIN.
  - When idx == length: go to FIN.
  - Entering the vacated former tail cell is legal; entering it on a growing move is fatal.
- FIN: done = 1 for exactly one cycle, then IDLE.
- Busy period: busy = 1 from ACCEPT through FIN inclusive.
  - Legal move: L + L + 1 cycles (1 ACCEPT + L SHIFT + (L-1) CHECK + 1 FIN), where L is the post-grow length.
  - Wall death: 2 cycles.
- Pixel query:
  - px_head and px_body are registered from px_x/px_y and the segment state at the sampling edge.
  - Segments at index >= length never hit.
- Arithmetic: coordinates are unsigned; length saturates at MAX_LEN and grow is then silently dropped.

Optional Feature:
SNAKE_WRAP_EN
- Defined: a head stepping past X_MAX wraps to X_MIN, and past X_MIN wraps to X_MAX; y wraps the same way. Walls are never fatal; only self-collision sets dead.
- Undefined: leaving the arena sets dead as specified in ACCEPT.

Test Plan:
1. Reset, then start with (10,10), then move_tick with dir=3 -> done after 3 cycles; head (11,10), length 1, dead 0.
2. At length 1, grow then move_tick with dir=0 from (11,10) -> length 2, head (11,9), seg1 (11,10), busy for 5 cycles; query (11,10) -> px_body 1, px_head 0 one cycle later.
3. With cur_dir right, move_tick with dir=1 -> reversal ignored, head x increments by 1.
4. Head at (X_MAX,5), dir=3, move_tick:
   - Without SNAKE_WRAP_EN -> dead 1, done after 2 cycles, head unchanged, further ticks ignored.
   - With it -> head (X_MIN,5).
5. Length-5 snake driven in a tight square so the head lands on seg4 while growing -> dead 1 at FIN; the same path without grow -> dead 0.
6. start asserted mid-SHIFT while dead=1 -> next cycle busy 0, dead 0, length 1, no done pulse.
